// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared constants, FSM state type, debug view and the per-digit BCD add rule
// used by the serial BCD adder controller.
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_CORR    = 4'd6;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam int         DBG_IDX_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_ctrl_state_t;

  typedef struct packed {
    bcd_ctrl_state_t        state;
    logic [DBG_IDX_W-1:0]   idx;
  } bcd_ctrl_dbg_t;

  // One BCD digit add: returns {decimal_carry, digit}. The correction wraps mod 16,
  // so illegal input digits still produce a deterministic 4-bit result.
  function automatic logic [BCD_DIGIT_W:0] bcd_digit_add(
    input logic [BCD_DIGIT_W-1:0] a,
    input logic [BCD_DIGIT_W-1:0] b,
    input logic                   cin
  );
    logic [BCD_DIGIT_W:0]   s;
    logic                   dc;
    logic [BCD_DIGIT_W-1:0] d;
    s  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
    dc = s[4] | (s[3] & s[2]) | (s[3] & s[1]);
    d  = dc ? (s[3:0] + BCD_CORR) : s[3:0];
    return {dc, d};
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/response bundle of the serial BCD adder controller.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_a;
  logic [4*DIGITS-1:0]   in_b;
  logic                  in_cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_sum;
  logic                  out_cout;
  logic                  out_err;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl_byte_add.sv
// Combinational 2-digit packed-BCD adder slice; the low digit's decimal carry
// feeds the high digit, whose decimal carry is the slice carry-out.
module bcd_byte_add
  import bcd_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [BCD_DIGIT_W:0] lo;
  logic [BCD_DIGIT_W:0] hi;

  always_comb begin
    lo   = bcd_digit_add(a[3:0], b[3:0], cin);
    hi   = bcd_digit_add(a[7:4], b[7:4], lo[BCD_DIGIT_W]);
    sum  = {hi[3:0], lo[3:0]};
    cout = hi[BCD_DIGIT_W];
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder controller: streams a wide BCD addition through one
// 2-digit slice, least-significant byte first, with valid/ready on both sides.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_serial_add_ctrl_if.slave   bus,
  output bcd_ctrl_dbg_t          dbg
);

  localparam int W  = 4 * DIGITS;
  localparam int NB = DIGITS / 2;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  bcd_ctrl_state_t state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            err_q, err_d;
  logic [W-1:0]    out_sum_q, out_sum_d;
  logic            out_cout_q, out_cout_d;
  logic            out_err_q, out_err_d;

  logic [7:0]      slice_a, slice_b, slice_sum;
  logic            slice_cout;
  logic            in_bad;
  int unsigned     base;

  bcd_byte_add u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Byte lane currently being added.
  always_comb begin
    base    = 8 * int'(idx_q);
    slice_a = a_q[base +: 8];
    slice_b = b_q[base +: 8];
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.in_a[4*i +: 4] > BCD_MAX || bus.in_b[4*i +: 4] > BCD_MAX) begin
        in_bad = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    sum_d      = sum_q;
    err_d      = err_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_err_d  = out_err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          sum_d   = '0;
          err_d   = in_bad;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: 8] = slice_sum;
        carry_d          = slice_cout;
        if (idx_q == LAST_IDX) begin
          // Result registers take the merged sum including this final byte.
          state_d    = DONE;
          idx_d      = '0;
          out_sum_d  = sum_d;
          out_cout_d = slice_cout;
          out_err_d  = err_q;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      err_q      <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_err_q  <= out_err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_err   = out_err_q;

  assign dbg.state = state_q;
  assign dbg.idx   = DBG_IDX_W'(idx_q);

endmodule
